bsg_debug_halt_sequencer: RTL

//  Controller and arbiter for the single AXI-lite master FIFO port of the debug subsystem.

---
 rtl/bsg_debug_halt_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/bsg_debug_halt_sequencer.sv
// Debug halt sequencer: arbitrates the single AXI-lite master FIFO port between the debug
// module's system-bus master (SBA) and a four-write halt sequence (NPC redirect, software
// interrupt raise/lower, unfreeze). At most one transaction is outstanding on the port.
module bsg_debug_halt_sequencer #(
   parameter int unsigned              addr_width_p  = 32,
   parameter int unsigned              data_width_p  = 32,
   parameter logic [addr_width_p-1:0]  npc_addr_p    = 32'h0020_0010,
   parameter logic [data_width_p-1:0]  npc_data_p    = 32'h0013_0800,
   parameter logic [addr_width_p-1:0]  irq_addr_p    = 32'h0030_C000,
   parameter logic [addr_width_p-1:0]  freeze_addr_p = 32'h0020_0008,
   parameter int unsigned              cnt_width_p   = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        debug_req_i,
   input  logic                        dm_req_i,
   input  logic                        dm_we_i,
   input  logic [addr_width_p-1:0]     dm_addr_i,
   input  logic [data_width_p-1:0]     dm_wdata_i,
   input  logic [data_width_p/8-1:0]   dm_be_i,
   output logic                        dm_gnt_o,
   output logic                        dm_r_valid_o,
   output logic [data_width_p-1:0]     dm_r_rdata_o,
   output logic                        dm_r_err_o,
   output logic                        fifo_v_o,
   output logic                        fifo_w_o,
   output logic [addr_width_p-1:0]     fifo_addr_o,
   output logic [data_width_p-1:0]     fifo_data_o,
   output logic [data_width_p/8-1:0]   fifo_wmask_o,
   input  logic                        fifo_ready_and_i,
   input  logic                        fifo_v_i,
   input  logic [data_width_p-1:0]     fifo_data_i,
   output logic                        fifo_ready_and_o,
   output logic                        busy_o,
   output logic [cnt_width_p-1:0]      seq_cnt_o
);

   typedef enum logic [2:0] {
      StIdle, StNpc, StHiReq, StLoReq, StUnfreeze, StWaitDrop
   } state_e;

   state_e                 state_q, state_d;
   logic                   outstanding_q, outstanding_d;
   logic                   owner_q, owner_d;
   logic                   sent_q, sent_d;
   logic [cnt_width_p-1:0] seq_cnt_q, seq_cnt_d;

   logic                    seq_sel, sba_sel;
   logic [addr_width_p-1:0] seq_addr;
   logic [data_width_p-1:0] seq_data;
   logic                    start, seq_rsp, accept;

   // A new sequence may only start once any SBA transaction has drained.
   assign start   = debug_req_i & ~outstanding_q;
   // Only responses owned by the sequencer advance the FSM; stale ones have outstanding_q=0.
   assign seq_rsp = fifo_v_i & outstanding_q & owner_q;

   // Next-state logic and per-state port selection.
   always_comb begin
      state_d  = state_q;
      seq_sel  = 1'b0;
      sba_sel  = 1'b0;
      seq_addr = '0;
      seq_data = '0;
      case (state_q)
         StIdle: begin
            if (start) state_d = StNpc;
            else       sba_sel = 1'b1;
         end
         StNpc: begin
            seq_sel  = 1'b1;
            seq_addr = npc_addr_p;
            seq_data = npc_data_p;
            if (seq_rsp) state_d = StHiReq;
         end
         StHiReq: begin
            seq_sel  = 1'b1;
            seq_addr = irq_addr_p;
            seq_data = data_width_p'(1);
            if (seq_rsp) state_d = StLoReq;
         end
         StLoReq: begin
            seq_sel  = 1'b1;
            seq_addr = irq_addr_p;
            if (seq_rsp) state_d = StUnfreeze;
         end
         StUnfreeze: begin
            seq_sel  = 1'b1;
            seq_addr = freeze_addr_p;
            if (seq_rsp) state_d = StWaitDrop;
         end
         StWaitDrop: begin
            sba_sel = 1'b1;
            if (!debug_req_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // FIFO request mux: sequencer write, SBA pass-through, or idle.
   always_comb begin
      fifo_v_o     = 1'b0;
      fifo_w_o     = 1'b0;
      fifo_addr_o  = '0;
      fifo_data_o  = '0;
      fifo_wmask_o = '0;
      if (seq_sel) begin
         fifo_v_o     = ~outstanding_q & ~sent_q;
         fifo_w_o     = 1'b1;
         fifo_addr_o  = seq_addr;
         fifo_data_o  = seq_data;
         fifo_wmask_o = '1;
      end else if (sba_sel) begin
         fifo_v_o     = dm_req_i & ~outstanding_q;
         fifo_w_o     = dm_we_i;
         fifo_addr_o  = dm_addr_i;
         fifo_data_o  = dm_wdata_i;
         fifo_wmask_o = dm_be_i;
      end
   end

   assign accept = fifo_v_o & fifo_ready_and_i;

   // Outstanding/owner/sent bookkeeping and the completed-sequence counter.
   always_comb begin
      outstanding_d = outstanding_q;
      owner_d       = owner_q;
      sent_d        = sent_q;
      seq_cnt_d     = seq_cnt_q;
      if (fifo_v_i) outstanding_d = 1'b0;
      if (accept) begin
         outstanding_d = 1'b1;
         owner_d       = seq_sel;
      end
      if (seq_rsp)                sent_d = 1'b0;
      else if (seq_sel && accept) sent_d = 1'b1;
      if (seq_rsp && state_q == StUnfreeze) seq_cnt_d = seq_cnt_q + 1'b1;
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StIdle;
         outstanding_q <= 1'b0;
         owner_q       <= 1'b0;
         sent_q        <= 1'b0;
         seq_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         outstanding_q <= outstanding_d;
         owner_q       <= owner_d;
         sent_q        <= sent_d;
         seq_cnt_q     <= seq_cnt_d;
      end
   end

   assign dm_gnt_o         = sba_sel & accept;
   assign dm_r_valid_o     = fifo_v_i & outstanding_q & ~owner_q;
   assign dm_r_rdata_o     = fifo_data_i;
   assign dm_r_err_o       = 1'b0;
   assign fifo_ready_and_o = 1'b1;
   assign busy_o           = seq_sel;
   assign seq_cnt_o        = seq_cnt_q;

endmodule
